// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared edge-mode encodings and counter-width helpers for the button conditioner
package btn_pkg;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one conditioner channel: synchroniser, stable-count debounce, edge and hold/repeat pulses
module button_channel
    import btn_pkg::*;
#(
    parameter int         DEB_CYCLES  = 16,
    parameter int         HOLD_CYCLES = 1000,
    parameter int         RPT_CYCLES  = 200,
    parameter logic [1:0] EDGE_MODE   = EDGE_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic level,
    output logic rise_p,
    output logic fall_p,
    output logic press_p,
    output logic rpt_p
);

    localparam int DW = clog2(DEB_CYCLES + 1);
    localparam int HW = clog2(max_int(HOLD_CYCLES, RPT_CYCLES) + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(RPT_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          level_q, level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rpt_seen_q, rpt_seen_d;
    logic          rpt_q, rpt_d;
    logic [HW-1:0] hold_limit;

    always_comb begin
        s1_d      = sig_in;
        s2_d      = s1_q;
        level_d   = level_q;
        deb_cnt_d = '0;
        // the level flips on the edge where the count would reach DEB_CYCLES
        if (s2_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;

        // hold count is 0 in the rise_p cycle because level_q was still low one edge earlier
        hold_limit = rpt_seen_q ? RPT_LAST : HOLD_LAST;
        hold_cnt_d = '0;
        rpt_seen_d = 1'b0;
        rpt_d      = 1'b0;
        if (level_q) begin
            rpt_seen_d = rpt_seen_q;
            if (hold_cnt_q == hold_limit) begin
                rpt_d      = level_d;
                rpt_seen_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            level_q    <= 1'b0;
            deb_cnt_q  <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            hold_cnt_q <= '0;
            rpt_seen_q <= 1'b0;
            rpt_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            level_q    <= level_d;
            deb_cnt_q  <= deb_cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            hold_cnt_q <= hold_cnt_d;
            rpt_seen_q <= rpt_seen_d;
            rpt_q      <= rpt_d;
        end
    end

    always_comb begin
        press_p = rise_q;
        case (EDGE_MODE)
            EDGE_FALL: press_p = fall_q;
            EDGE_BOTH: press_p = rise_q | fall_q;
            default:   press_p = rise_q;
        endcase
    end

    assign level  = level_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;
    assign rpt_p  = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_CH independent button channels for the clock's push-buttons and switches
module button_conditioner
    import btn_pkg::*;
#(
    parameter int         N_CH        = 4,
    parameter int         DEB_CYCLES  = 16,
    parameter int         HOLD_CYCLES = 1000,
    parameter int         RPT_CYCLES  = 200,
    parameter logic [1:0] EDGE_MODE   = EDGE_RISE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sig_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise_p,
    output logic [N_CH-1:0] fall_p,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] rpt_p
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .RPT_CYCLES (RPT_CYCLES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .sig_in (sig_in[i]),
            .level  (level[i]),
            .rise_p (rise_p[i]),
            .fall_p (fall_p[i]),
            .press_p(press_p[i]),
            .rpt_p  (rpt_p[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;
    localparam int NEVER = 1000;

    logic       clk;
    logic       rst_n;
    logic [1:0] sig_in;
    logic [1:0] level_r, rise_r, fall_r, press_r, rpt_r;
    logic [1:0] level_b, rise_b, fall_b, press_b, rpt_b;

    int n_chk;
    int n_bad;

    button_conditioner #(
        .N_CH(2), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT), .EDGE_MODE(EDGE_RISE)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .level(level_r), .rise_p(rise_r), .fall_p(fall_r), .press_p(press_r), .rpt_p(rpt_r)
    );

    button_conditioner #(
        .N_CH(2), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT), .EDGE_MODE(EDGE_BOTH)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .level(level_b), .rise_p(rise_b), .fall_p(fall_b), .press_p(press_b), .rpt_p(rpt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " r"}, {level_r, rise_r, fall_r, press_r, rpt_r}, 32'd0);
        chk({tag, " b"}, {level_b, rise_b, fall_b, press_b, rpt_b}, 32'd0);
    endtask

    // kp/kr: edge index that first samples the press/release of each channel
    task automatic run_scn(input int kp0, input int kr0, input int kp1, input int kr1,
                           input int n, input string name);
        int kp[2];
        int kr[2];
        logic [1:0] el, er, ef, erp;
        kp[0] = kp0; kr[0] = kr0;
        kp[1] = kp1; kr[1] = kr1;
        for (int e = 0; e < n; e++) begin
            for (int c = 0; c < 2; c++) begin
                sig_in[c] = (e >= kp[c]) && (e < kr[c]);
            end
            tick();
            for (int c = 0; c < 2; c++) begin
                int r;
                int f;
                r = kp[c] + DEB + 1;
                f = kr[c] + DEB + 1;
                el[c]  = (e >= r) && (e < f);
                er[c]  = (e == r);
                ef[c]  = (e == f);
                erp[c] = (e >= r + HOLD) && (((e - r - HOLD) % RPT) == 0) && (e < f);
            end
            chk($sformatf("%s e%0d level", name, e), 32'(level_r), 32'(el));
            chk($sformatf("%s e%0d rise", name, e), 32'(rise_r), 32'(er));
            chk($sformatf("%s e%0d fall", name, e), 32'(fall_r), 32'(ef));
            chk($sformatf("%s e%0d press", name, e), 32'(press_r), 32'(er));
            chk($sformatf("%s e%0d rpt", name, e), 32'(rpt_r), 32'(erp));
            chk($sformatf("%s e%0d both_press", name, e), 32'(press_b), 32'(er | ef));
            chk($sformatf("%s e%0d both_rpt", name, e), 32'(rpt_b), 32'(erp));
        end
    endtask

    initial begin
        n_chk  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        sig_in = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero($sformatf("reset c%0d", i));
        end
        rst_n = 1'b1;
        tick();
        chk_zero("idle");

        // clean press, hold/repeat, release landing on a would-be repeat cycle
        run_scn(0, 31, NEVER, NEVER, 46, "hold");

        // bounce: three-cycle pulses never reach the debounce count
        for (int e = 0; e < 30; e++) begin
            sig_in[0] = (e < 12) && (((e / 3) % 2) == 0);
            tick();
            chk_zero($sformatf("bounce e%0d", e));
        end

        // release before the hold time elapses
        run_scn(0, 8, NEVER, NEVER, 22, "short");

        // two channels offset by two cycles
        run_scn(0, 20, 2, 22, 34, "indep");

        // reset while repeats are active, input still held through and after reset
        run_scn(0, NEVER, NEVER, NEVER, 20, "pre_rst");
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero($sformatf("mid_rst c%0d", i));
        end
        rst_n = 1'b1;
        run_scn(0, 20, NEVER, NEVER, 34, "post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
